// File: rtl/cell_editor_if.sv
// cell_editor_if: command handshake, board-memory port and status bundle for the cell editor.
interface cell_editor_if #(
  parameter int LOG_BOARD_SIZE = 6,
  parameter int WORD_SIZE = 16,
  parameter int LOG_MAX_ADDR = 8
);
  logic req_valid;
  logic req_ready;
  logic [1:0] req_op;
  logic [LOG_BOARD_SIZE-1:0] cell_x;
  logic [LOG_BOARD_SIZE-1:0] cell_y;
  logic [LOG_MAX_ADDR-1:0] addr;
  logic [WORD_SIZE-1:0] data_r;
  logic [WORD_SIZE-1:0] data_w;
  logic we;
  logic busy;
  logic done;
  modport master (
    output req_valid, req_op, cell_x, cell_y, data_r,
    input req_ready, addr, data_w, we, busy, done
  );
  modport slave (
    input req_valid, req_op, cell_x, cell_y, data_r,
    output req_ready, addr, data_w, we, busy, done
  );
endinterface

// File: rtl/cell_editor.sv
// cell_editor: turns cell toggle/set/clear and board-clear commands into BRAM read-modify-write or sweep writes.
module cell_editor #(
  parameter int BOARD_SIZE = 64,
  parameter int WORD_SIZE = 16,
  parameter int READ_LATENCY = 2,
  parameter int LOG_BOARD_SIZE = $clog2(BOARD_SIZE),
  parameter int LOG_WORD_SIZE = $clog2(WORD_SIZE),
  parameter int LOG_MAX_ADDR = $clog2(BOARD_SIZE * BOARD_SIZE / WORD_SIZE)
) (
  input logic clk,
  input logic rst,
  cell_editor_if.slave bus
);
  localparam int WORDS_PER_ROW = BOARD_SIZE / WORD_SIZE;
  localparam int TOTAL_WORDS = BOARD_SIZE * WORDS_PER_ROW;
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [LOG_MAX_ADDR-1:0] LAST = LOG_MAX_ADDR'(TOTAL_WORDS - 1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, CLEAR} state_t;
  state_t state, state_n;
  logic [LOG_MAX_ADDR-1:0] addr, mapped;
  logic [CW-1:0] cnt;
  logic [WORD_SIZE-1:0] word, mask, edited;
  logic [LOG_WORD_SIZE-1:0] bit_idx;
  logic [1:0] op;
  logic done, accept;
  assign accept = state == IDLE && bus.req_valid;
  assign mapped = LOG_MAX_ADDR'(bus.cell_y) * LOG_MAX_ADDR'(WORDS_PER_ROW)
                + LOG_MAX_ADDR'(bus.cell_x >> LOG_WORD_SIZE);
  // MSB-first layout: column offset 0 lands on bit WORD_SIZE-1
  assign mask = WORD_SIZE'(1) << bit_idx;
  assign edited = op == 2'b00 ? word ^ mask : op == 2'b01 ? word | mask : word & ~mask;
  assign bus.req_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.we = state == WRITE || state == CLEAR;
  assign bus.data_w = state == WRITE ? edited : '0;
  assign bus.addr = addr;
  assign bus.done = done;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.req_valid) state_n = bus.req_op == 2'b11 ? CLEAR : RD_WAIT;
      RD_WAIT: if (cnt == CW'(1)) state_n = WRITE;
      WRITE: state_n = IDLE;
      CLEAR: if (addr == LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      cnt <= '0;
      word <= '0;
      bit_idx <= '0;
      op <= '0;
      done <= 1'b0;
    end else begin
      done <= state == WRITE || (state == CLEAR && addr == LAST);
      if (accept) begin
        op <= bus.req_op;
        bit_idx <= ~bus.cell_x[LOG_WORD_SIZE-1:0];
        addr <= bus.req_op == 2'b11 ? '0 : mapped;
        cnt <= CW'(READ_LATENCY);
      end
      if (state == RD_WAIT) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) word <= bus.data_r;
      end
      if (state == CLEAR) addr <= addr + LOG_MAX_ADDR'(1);
    end
endmodule

// File: tb/tb_cell_editor.sv
// tb_cell_editor: randomized and directed checks of cell_editor against a word-array reference model.
module tb_cell_editor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic fill = 1'b0, poke_we = 1'b0;
  logic [15:0] fill_val = '0, poke_data = '0;
  logic [7:0] poke_addr = '0;
  cell_editor_if #(.LOG_BOARD_SIZE(6), .WORD_SIZE(16), .LOG_MAX_ADDR(8)) bus ();
  cell_editor #(.BOARD_SIZE(64), .WORD_SIZE(16), .READ_LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // BRAM model: read data for the address seen in cycle n is presented in cycle n+1
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 256; i++) mem[i] <= fill_val;
    else if (poke_we) mem[poke_addr] <= poke_data;
    else if (bus.we) mem[bus.addr] <= bus.data_w;
    bus.data_r <= mem[bus.addr];
  end
  function automatic int ref_addr(input int x, input int y);
    return y * 4 + x / 16;
  endfunction
  function automatic logic [15:0] ref_apply(input logic [1:0] op, input int x, input int y);
    logic [15:0] w;
    int b;
    w = ref_mem[ref_addr(x, y)];
    b = 15 - (x % 16);
    if (op == 2'b00) w[b] = ~w[b];
    else if (op == 2'b01) w[b] = 1'b1;
    else w[b] = 1'b0;
    ref_mem[ref_addr(x, y)] = w;
    return w;
  endfunction
  task automatic fill_mem(input logic [15:0] v);
    @(negedge clk);
    fill = 1'b1;
    fill_val = v;
    @(negedge clk);
    fill = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = v;
  endtask
  task automatic poke(input int a, input logic [15:0] d);
    @(negedge clk);
    poke_we = 1'b1;
    poke_addr = 8'(a);
    poke_data = d;
    @(negedge clk);
    poke_we = 1'b0;
    ref_mem[a] = d;
  endtask
  // Issues a command at the current negedge and observes until done (or budget); ends at done-cycle negedge
  task automatic run_cell(input logic [1:0] op, input int x, input int y,
                          output int we_n, output int we_c, output int done_c,
                          output logic [7:0] wa, output logic [15:0] wd);
    we_n = 0; we_c = 0; done_c = 0; wa = '0; wd = '0;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.cell_x = 6'(x);
    bus.cell_y = 6'(y);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op = 2'($urandom);
    bus.cell_x = 6'($urandom);
    bus.cell_y = 6'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (bus.we) begin
        we_n++;
        we_c = c;
        wa = bus.addr;
        wd = bus.data_w;
      end
      if (bus.done) begin
        done_c = c;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    bus.req_valid = 1'b1;
    bus.req_op = 2'b11;
    bus.cell_x = '0;
    bus.cell_y = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.busy, bus.done, bus.we} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_status: ready/busy/done/we=%b required 1000", {bus.req_ready, bus.busy, bus.done, bus.we});
    end
    checks++;
    if (bus.addr !== 8'd0 || bus.data_w !== 16'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%0d data_w=%h required 0/0000", bus.addr, bus.data_w);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: busy=%b ready=%b required 0/1", bus.busy, bus.req_ready);
    end
  endtask
  task automatic test_toggle;
    int we_n, we_c, done_c;
    logic [7:0] wa;
    logic [15:0] wd, exp;
    fill_mem(16'h0000);
    for (int k = 0; k < 2; k++) begin
      exp = ref_apply(2'b00, 5, 2);
      run_cell(2'b00, 5, 2, we_n, we_c, done_c, wa, wd);
      checks++;
      if (we_n !== 1 || we_c !== 3 || done_c !== 4) begin
        errors++;
        $display("FAIL toggle_timing: we_cycles=%0d we_at=%0d done_at=%0d required 1/3/4", we_n, we_c, done_c);
      end
      checks++;
      if (wa !== 8'd8 || wd !== exp) begin
        errors++;
        $display("FAIL toggle_write: addr=%0d data=%h required 8/%h", wa, wd, exp);
      end
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL toggle_ready_at_done: ready=%b required 1", bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (mem[8] !== (k == 0 ? 16'h0400 : 16'h0000)) begin
        errors++;
        $display("FAIL toggle_mem: mem[8]=%h required %h", mem[8], k == 0 ? 16'h0400 : 16'h0000);
      end
    end
  endtask
  task automatic test_set;
    int we_n, we_c, done_c;
    logic [7:0] wa;
    logic [15:0] wd;
    poke(1, 16'h0001);
    for (int k = 0; k < 2; k++) begin
      void'(ref_apply(2'b01, 16, 0));
      run_cell(2'b01, 16, 0, we_n, we_c, done_c, wa, wd);
      checks++;
      if (wa !== 8'd1 || wd !== 16'h8001 || done_c !== 4) begin
        errors++;
        $display("FAIL set_write: addr=%0d data=%h done_at=%0d required 1/8001/4", wa, wd, done_c);
      end
    end
  endtask
  task automatic test_clear_cell;
    int we_n, we_c, done_c;
    logic [7:0] wa;
    logic [15:0] wd;
    for (int a = 252; a <= 254; a++) poke(a, 16'hFFFF);
    void'(ref_apply(2'b10, 31, 63));
    run_cell(2'b10, 31, 63, we_n, we_c, done_c, wa, wd);
    checks++;
    if (wa !== 8'd253 || wd !== 16'hFFFE || we_n !== 1) begin
      errors++;
      $display("FAIL clear_cell_write: addr=%0d data=%h writes=%0d required 253/fffe/1", wa, wd, we_n);
    end
    @(negedge clk);
    checks++;
    if (mem[252] !== 16'hFFFF || mem[253] !== 16'hFFFE || mem[254] !== 16'hFFFF) begin
      errors++;
      $display("FAIL clear_cell_neighbours: mem252..254=%h %h %h required ffff fffe ffff", mem[252], mem[253], mem[254]);
    end
  endtask
  task automatic test_back_to_back;
    int we_n, we_c, done_c;
    logic [7:0] wa;
    logic [15:0] wd;
    poke(0, 16'h0000);
    void'(ref_apply(2'b01, 1, 0));
    run_cell(2'b01, 1, 0, we_n, we_c, done_c, wa, wd);
    void'(ref_apply(2'b00, 0, 0));
    run_cell(2'b00, 0, 0, we_n, we_c, done_c, wa, wd);
    checks++;
    if (wd !== 16'hC000 || wa !== 8'd0 || done_c !== 4) begin
      errors++;
      $display("FAIL b2b_write: addr=%0d data=%h done_at=%0d required 0/c000/4", wa, wd, done_c);
    end
    @(negedge clk);
    checks++;
    if (mem[0] !== ref_mem[0]) begin
      errors++;
      $display("FAIL b2b_mem: mem[0]=%h required %h", mem[0], ref_mem[0]);
    end
  endtask
  task automatic test_random;
    int we_n, we_c, done_c, x, y, bad;
    logic [7:0] wa;
    logic [15:0] wd, exp;
    logic [1:0] op;
    fill_mem(16'($urandom));
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 2));
      x = $urandom_range(0, 63);
      y = $urandom_range(0, 3);
      exp = ref_apply(op, x, y);
      if (n % 3 == 0) @(negedge clk);
      run_cell(op, x, y, we_n, we_c, done_c, wa, wd);
      checks++;
      if (wa !== 8'(ref_addr(x, y)) || wd !== exp || we_n !== 1 || done_c !== 4) begin
        errors++;
        $display("FAIL random_op%0d: op=%0d x=%0d y=%0d addr=%0d data=%h done_at=%0d required %0d/%h/4",
                 n, op, x, y, wa, wd, done_c, ref_addr(x, y), exp);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL random_mem: %0d words differ required 0", bad);
    end
  endtask
  task automatic test_clear_board;
    int we_n, done_c, seq_bad, ready_bad, nz;
    fill_mem(16'hA5A5);
    we_n = 0; done_c = 0; seq_bad = 0; ready_bad = 0; nz = 0;
    bus.req_valid = 1'b1;
    bus.req_op = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.req_op = 2'b00;
    bus.cell_x = 6'($urandom);
    bus.cell_y = 6'($urandom);
    for (int c = 1; c <= 400; c++) begin
      if (bus.we) begin
        we_n++;
        if (bus.addr !== 8'(c - 1) || bus.data_w !== 16'h0000) seq_bad++;
      end
      if (bus.done) begin
        done_c = c;
        bus.req_valid = 1'b0;
        break;
      end
      if (bus.req_ready !== 1'b0) ready_bad++;
      @(negedge clk);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    checks++;
    if (we_n !== 256 || done_c !== 257) begin
      errors++;
      $display("FAIL clear_board_timing: we_cycles=%0d done_at=%0d required 256/257", we_n, done_c);
    end
    checks++;
    if (seq_bad !== 0 || ready_bad !== 0) begin
      errors++;
      $display("FAIL clear_board_sweep: bad_addr_cycles=%0d ready_during_sweep=%0d required 0/0", seq_bad, ready_bad);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_board_after: done=%b busy=%b required 0/0", bus.done, bus.busy);
    end
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nz++;
    checks++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL clear_board_mem: %0d words not cleared required 0", nz);
    end
  endtask
  task automatic test_reset_mid_clear;
    int we_n, we_c, done_c, bad, dones;
    logic [7:0] wa;
    logic [15:0] wd, exp;
    fill_mem(16'hA5A5);
    bus.req_valid = 1'b1;
    bus.req_op = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 300 && !(bus.we && bus.addr == 8'd100); c++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.we !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: we=%b done=%b busy=%b required 0/0/0", bus.we, bus.done, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_status: done_pulses=%0d ready=%b required 0/1", dones, bus.req_ready);
    end
    for (int i = 0; i < 100; i++) ref_mem[i] = 16'h0000;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_mem: %0d words differ from partial clear required 0", bad);
    end
    exp = ref_apply(2'b00, 40, 30);
    run_cell(2'b00, 40, 30, we_n, we_c, done_c, wa, wd);
    checks++;
    if (wa !== 8'd122 || wd !== exp || done_c !== 4) begin
      errors++;
      $display("FAIL abort_next_toggle: addr=%0d data=%h done_at=%0d required 122/%h/4", wa, wd, done_c, exp);
    end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.cell_x = '0;
    bus.cell_y = '0;
    test_reset();
    test_toggle();
    test_set();
    test_clear_cell();
    test_back_to_back();
    test_random();
    test_clear_board();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
